// File: rtl/spi_mem_slave.sv
// SPI mode-0 memory slave: READ/FAST_READ/WRITE plus mode register access.
// Sits between sampled SPI pin strobes and a synchronous single-port byte memory.
module spi_mem_slave #(
  parameter int ADDR_BITS  = 24,
  parameter int PAGE_BITS  = 5,
  parameter int DUMMY_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 en2,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic [1:0]           mode,
  output logic                 cmd_err,
  output logic [3:0]           dbg_state
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CMD    = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_DUMMY  = 4'd3;
  localparam logic [3:0] S_RDATA  = 4'd4;
  localparam logic [3:0] S_WDATA  = 4'd5;
  localparam logic [3:0] S_MRD    = 4'd6;
  localparam logic [3:0] S_MWR    = 4'd7;
  localparam logic [3:0] S_IGNORE = 4'd8;

  localparam logic [PAGE_BITS-1:0] PAGE_ONE = PAGE_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  logic [3:0]           state;
  logic [7:0]           cnt;
  logic [6:0]           shreg;
  logic [7:0]           op;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] addr_shift;
  logic [ADDR_BITS-1:0] addr_next;
  logic [7:0]           out_sr;
  logic [7:0]           rd_src;
  logic [7:0]           rx_byte;
  logic                 rd_pend;

  assign dbg_state = state;

  // Fresh read data bypasses out_sr so an en2 landing on the capture clk still sees it.
  always_comb begin
    addr_shift = {addr[ADDR_BITS-2:0], mosi};
    rx_byte    = {shreg, mosi};
    rd_src     = (rd_pend && state == S_RDATA) ? mem_rdata : out_sr;
    if (mode == 2'b10) addr_next = {addr[ADDR_BITS-1:PAGE_BITS], addr[PAGE_BITS-1:0] + PAGE_ONE};
    else               addr_next = addr + ADDR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      op        <= '0;
      addr      <= '0;
      out_sr    <= '0;
      rd_pend   <= 1'b0;
      mode      <= 2'b01;
      miso      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      cmd_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      cmd_err <= 1'b0;
      rd_pend <= mem_en & ~mem_wr;
      if (cs_n) begin
        state   <= S_IDLE;
        miso    <= 1'b0;
        rd_pend <= 1'b0;
        cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            miso  <= 1'b0;
            state <= S_CMD;
            if (en) begin
              shreg <= {shreg[5:0], mosi};
              cnt   <= 8'd1;
            end else begin
              cnt <= 8'd0;
            end
          end
          S_CMD: begin
            miso <= 1'b0;
            if (en) begin
              shreg <= {shreg[5:0], mosi};
              if (cnt == 8'd7) begin
                cnt <= '0;
                op  <= rx_byte;
                case (rx_byte)
                  8'h03, 8'h0B, 8'h02: state <= S_ADDR;
                  8'h05: begin
                    state  <= S_MRD;
                    out_sr <= {mode, 6'b0};
                  end
                  8'h01: state <= S_MWR;
                  default: begin
                    cmd_err <= 1'b1;
                    state   <= S_IGNORE;
                  end
                endcase
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_ADDR: begin
            miso <= 1'b0;
            if (en) begin
              addr <= addr_shift;
              if (cnt == 8'(ADDR_BITS - 1)) begin
                cnt <= '0;
                if (op == 8'h0B) begin
                  state <= S_DUMMY;
                end else if (op == 8'h03) begin
                  state    <= S_RDATA;
                  mem_en   <= 1'b1;
                  mem_addr <= addr_shift;
                end else begin
                  state <= S_WDATA;
                end
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_DUMMY: begin
            miso <= 1'b0;
            if (en) begin
              if (cnt == 8'(DUMMY_BITS - 1)) begin
                cnt      <= '0;
                state    <= S_RDATA;
                mem_en   <= 1'b1;
                mem_addr <= addr;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_RDATA: begin
            if (en2) begin
              miso   <= rd_src[7];
              out_sr <= {rd_src[6:0], 1'b0};
            end else if (rd_pend) begin
              out_sr <= mem_rdata;
            end
            // Prefetch the next byte as soon as the master has sampled bit 0.
            if (en) begin
              if (cnt == 8'd7) begin
                cnt <= '0;
                if (mode == 2'b00) begin
                  state <= S_IGNORE;
                end else begin
                  addr     <= addr_next;
                  mem_addr <= addr_next;
                  mem_en   <= 1'b1;
                end
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_WDATA: begin
            miso <= 1'b0;
            if (en) begin
              shreg <= {shreg[5:0], mosi};
              if (cnt == 8'd7) begin
                cnt       <= '0;
                mem_en    <= 1'b1;
                mem_wr    <= 1'b1;
                mem_wdata <= rx_byte;
                mem_addr  <= addr;
                addr      <= addr_next;
                if (mode == 2'b00) state <= S_IGNORE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_MRD: begin
            if (en2) begin
              miso   <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
            end
            if (en) begin
              if (cnt == 8'd7) begin
                cnt    <= '0;
                out_sr <= {mode, 6'b0};
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_MWR: begin
            miso <= 1'b0;
            if (en) begin
              shreg <= {shreg[5:0], mosi};
              if (cnt == 8'd7) begin
                cnt   <= '0;
                mode  <= shreg[6:5];
                state <= S_IGNORE;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
          S_IGNORE: miso <= 1'b0;
          default: begin
            state <= S_IDLE;
            miso  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_mem_slave.md
Name: spi_mem_slave

Overview:
Parametrised SPI mode-0 memory slave, successor to the fixed 24-bit READ/WRITE slave. It adds configurable address width, a FAST_READ opcode with dummy cycles, and a mode register (byte/page/sequential) with RDMR/WRMR access and page-wrap addressing. It sits between an SPI pin interface, already sampled into the system clock domain as strobes, and a synchronous single-port byte memory.

Parameters:
ADDR_BITS, 24, address width in bits; legal values 16 or 24; address bytes sent = ADDR_BITS/8.
PAGE_BITS, 5, log2 of page size in bytes for page mode; must be < ADDR_BITS.
DUMMY_BITS, 8, SCK cycles between the last address bit and the first data bit for FAST_READ.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
en  in  1  one-clk strobe at the SCK rising edge; mosi is sampled and the state advances.
en2  in  1  one-clk strobe at the SCK falling edge; miso updates.
cs_n  in  1  chip select, synchronised, sampled every clk.
mosi  in  1  serial data in, MSB first.
miso  out  1  serial data out, MSB first.
mem_addr  out  ADDR_BITS  memory address.
mem_en  out  1  memory access strobe, one clk wide.
mem_wr  out  1  write qualifier, valid with mem_en.
mem_wdata  out  8  write data.
mem_rdata  in  8  read data, valid the clk after mem_en with mem_wr=0.
mode  out  2  current mode register bits 7:6.
cmd_err  out  1  one-clk pulse on an unsupported opcode.

Behaviour:
- Reset (rst_n low, async): state=IDLE, mode=2'b01 (sequential), miso=0, mem_en=0, mem_wr=0, cmd_err=0, mem_addr=0, mem_wdata=0.
- Opcodes: 0x03 READ, 0x0B FAST_READ, 0x02 WRITE, 0x05 RDMR, 0x01 WRMR. Any other opcode pulses cmd_err and enters IGNORE. In IGNORE, miso=0 and there are no memory accesses until cs_n goes high.
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_BITS bits; skipped for RDMR/WRMR) -> DUMMY (FAST_READ only, DUMMY_BITS bits) -> RDATA or WDATA or MRD or MWR -> IGNORE or IDLE.
- Bit counters reload on every state change. All shifting happens only on en cycles.
- Reads: mem_en pulses (mem_wr=0) on the clk after the en that samples the last address or dummy bit. mem_rdata is captured one clk later into the output shift register.
  - The first en2 after capture drives bit 7 on miso.
  - Each subsequent byte is prefetched: mem_en pulses on the clk after the en that samples bit 0 of the current byte.
  - The prefetch address is the current address advanced per mode.
- Writes: after the 8th data bit of each byte is sampled, mem_en=1, mem_wr=1 and mem_wdata=the byte for one clk, with the current address. The address then advances per mode.
- Address advance:
  - Sequential: addr+1, wrapping modulo 2^ADDR_BITS.
  - Page: low PAGE_BITS bits increment and wrap; upper bits are held.
  - Byte: after the first data byte, go to IGNORE. Reads then drive miso=0; writes are dropped.
- Mode values: mode=2'b11 is reserved and behaves as sequential.
- WRMR: the 8-bit byte is shifted in and mode<=byte[7:6] on the 8th bit; further bytes are ignored.
- RDMR: miso shifts out {mode,6'b0}, repeated every byte while cs_n stays low.
- cs_n high on any clk: state->IDLE on the next clk.
  - Partial data byte: discarded, no write issued.
  - Outstanding prefetch: result discarded.
  - miso: goes to 0.
- cs_n low with en in the same clk as IDLE exit: that en samples opcode bit 7.
- Address for a new command comes entirely from the ADDR phase; nothing is retained across cs_n cycles except mode.
- Timing constraint: there must be at least 2 clk between an en and the following en2. The bench guarantees this; RDATA timing relies on it.

Test Plan:
- WRITE 0x02, addr 0x000010, data 0xA5,0x5A (sequential) -> mem writes 0xA5@0x000010 and 0x5A@0x000011. Then READ 0x03 at 0x000010 for 2 bytes -> miso returns 0xA5,0x5A.
- WRMR 0x80 (page mode), then WRITE at 0x00001F with 2 bytes 0x11,0x22 -> writes 0x11@0x00001F and 0x22@0x000000. RDMR then returns 0x80; mode=2'b10.
- WRMR 0x00 (byte mode), WRITE at 0x000100 with 0x33,0x44 -> one write of 0x33@0x000100 only. A READ of 2 bytes returns 0x33 then 0x00.
- FAST_READ 0x0B, addr 0x000010, 8 dummy bits -> first miso bit appears on the en2 after the 8th dummy bit; byte = 0xA5.
- Opcode 0x9F -> cmd_err single-clk pulse, no mem_en for the rest of the transaction, miso=0. The next transaction after cs_n high decodes normally.
- WRITE raising cs_n after 4 data bits, and rst_n pulsed mid-READ -> no mem write issued, state IDLE, mode=2'b01 after reset, miso=0.
